// File: rtl/fifo_read_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_read_ctrl
//   Read-side controller of the FIFO. It owns the read pointer, issues
//   synchronous reads to the FIFO RAM and holds the returned words in a
//   2-entry output stage. The consumer sees a first-word-fall-through
//   valid/ready interface that sustains one word per cycle.
//
//   Optional feature: define PTR_CHECK_EN to build the sticky pointer-sanity
//   check behind ptr_err. Without it, ptr_err is tied low.
//
// Ports
//   clk        in   1       single clock, rising edge
//   rst_n      in   1       asynchronous active-low reset
//   w_pointer  in   SIZE    write pointer from the write controller
//   rd_en      out  1       RAM read strobe (combinational issue)
//   rd_addr    out  SIZE-1  RAM read address (r_pointer without wrap bit)
//   rd_data    in   DATA_W  RAM read data, valid one cycle after rd_en
//   r_pointer  out  SIZE    read pointer (registered)
//   ram_empty  out  1       w_pointer == r_pointer (combinational)
//   dout       out  DATA_W  head word
//   dout_valid out  1       head word valid
//   dout_ready in   1       consumer accepts head word
//   ptr_err    out  1       sticky pointer-sanity error
// ---------------------------------------------------------------------------
module fifo_read_ctrl #(
    parameter int SIZE   = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SIZE-1:0]   w_pointer,
    output logic              rd_en,
    output logic [SIZE-2:0]   rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [SIZE-1:0]   r_pointer,
    output logic              ram_empty,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              ptr_err
);

    // State encoding doubles as the count of words held in the output stage.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } out_state_e;

    out_state_e        state, state_next;
    logic [DATA_W-1:0] out_reg, out_next;
    logic [DATA_W-1:0] skid_reg, skid_next;
    logic              pend;
    logic              pop;
    logic              issue;
    logic [2:0]        occupancy;

    assign ram_empty  = (w_pointer == r_pointer);
    assign pop        = dout_valid & dout_ready;

    // Words held plus the one in flight, minus the one leaving this cycle.
    // pop implies at least one word held, so this never underflows.
    assign occupancy  = {1'b0, state} + {2'b00, pend} - {2'b00, pop};
    assign issue      = !ram_empty && (occupancy < 3'd2);

    assign rd_en      = issue;
    assign rd_addr    = r_pointer[SIZE-2:0];
    assign dout       = out_reg;
    assign dout_valid = (state != S_EMPTY);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its peers, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pointer <= '0;
            pend      <= 1'b0;
        end else begin
            pend <= issue;
            if (issue) begin
                r_pointer <= r_pointer + SIZE'(1);
            end
        end
    end

    // NOTE: the data holding registers are reset as well, because dout is
    // required to read 0 out of reset rather than stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_EMPTY;
            out_reg  <= '0;
            skid_reg <= '0;
        end else begin
            state    <= state_next;
            out_reg  <= out_next;
            skid_reg <= skid_next;
        end
    end

    // A read issued last cycle (pend) delivers its word on rd_data now.
    // NOTE: every output of this block gets a hold default first so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        out_next   = out_reg;
        skid_next  = skid_reg;
        case (state)
            S_EMPTY: begin
                if (pend) begin
                    state_next = S_ONE;
                    out_next   = rd_data;
                end
            end
            S_ONE: begin
                if (pend && !pop) begin
                    state_next = S_TWO;
                    skid_next  = rd_data;
                end else if (pend && pop) begin
                    out_next   = rd_data;
                end else if (pop) begin
                    state_next = S_EMPTY;
                end
            end
            S_TWO: begin
                if (pop) begin
                    out_next = skid_reg;
                    if (pend) begin
                        skid_next  = rd_data;
                    end else begin
                        state_next = S_ONE;
                    end
                end
            end
            default: begin
                state_next = S_EMPTY;
            end
        endcase
    end

    // The issue rule keeps at most two words owned by the output stage, so a
    // word can never arrive into a full stage that is not draining.
    no_overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(state == S_TWO && pend && !pop));

`ifdef PTR_CHECK_EN
    localparam logic [SIZE-1:0] DEPTH_PTR = SIZE'(2 ** (SIZE - 1));

    logic [SIZE-1:0] ptr_dist;

    // Unread words in the RAM; more than DEPTH means the writer overran us.
    assign ptr_dist = w_pointer - r_pointer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_err <= 1'b0;
        end else if (ptr_dist > DEPTH_PTR) begin
            ptr_err <= 1'b1;
        end
    end
`else
    assign ptr_err = 1'b0;
`endif

endmodule
